// File: rtl/walker_pkg.sv
// Shared state type, subsample codes and step decode for the sample walker.
package walker_pkg;

  typedef enum logic {StWait, StTest} walk_state_e;

  localparam logic [3:0] SubPx1 = 4'b1000;
  localparam logic [3:0] SubPx2 = 4'b0100;
  localparam logic [3:0] SubPx4 = 4'b0010;
  localparam logic [3:0] SubPx8 = 4'b0001;

  // Returns k where step = 1 << (RADIX - k); any non-one-hot code falls back to 1 px.
  function automatic logic [1:0] step_shift(input logic [3:0] sub);
    case (sub)
      SubPx1:  step_shift = 2'd0;
      SubPx2:  step_shift = 2'd1;
      SubPx4:  step_shift = 2'd2;
      SubPx8:  step_shift = 2'd3;
      default: step_shift = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/sample_walk_next.sv
// Combinational next-sample generator: raster order, or alternating rows when
// WALKER_SERPENTINE_EN is defined.
module sample_walk_next
  import walker_pkg::*;
#(
  parameter int unsigned SIGFIG = 24
) (
  input  logic signed [SIGFIG-1:0] cur_x_i,
  input  logic signed [SIGFIG-1:0] cur_y_i,
  input  logic signed [SIGFIG-1:0] ll_x_i,
  input  logic signed [SIGFIG-1:0] ll_y_i,
  input  logic signed [SIGFIG-1:0] ur_x_i,
  input  logic signed [SIGFIG-1:0] ur_y_i,
  input  logic        [SIGFIG:0]   step_i,
  input  logic                     dir_i,
  output logic signed [SIGFIG-1:0] nxt_x_o,
  output logic signed [SIGFIG-1:0] nxt_y_o,
  output logic                     dir_o,
  output logic                     last_o
);

  // One guard bit so steps past the positive limit compare correctly instead of wrapping.
  logic signed [SIGFIG:0] x_w, y_w, llx_w, lly_w, urx_w, ury_w, stp_w, x_fwd, y_inc;
  logic row_done, col_done, inverted;

  assign x_w   = {cur_x_i[SIGFIG-1], cur_x_i};
  assign y_w   = {cur_y_i[SIGFIG-1], cur_y_i};
  assign llx_w = {ll_x_i[SIGFIG-1], ll_x_i};
  assign lly_w = {ll_y_i[SIGFIG-1], ll_y_i};
  assign urx_w = {ur_x_i[SIGFIG-1], ur_x_i};
  assign ury_w = {ur_y_i[SIGFIG-1], ur_y_i};
  assign stp_w = $signed(step_i);

  assign x_fwd    = x_w + stp_w;
  assign y_inc    = y_w + stp_w;
  assign col_done = y_inc > ury_w;
  assign inverted = (urx_w < llx_w) || (ury_w < lly_w);
  assign last_o   = (row_done && col_done) || inverted;

`ifdef WALKER_SERPENTINE_EN
  logic signed [SIGFIG:0] x_bwd;

  assign x_bwd    = x_w - stp_w;
  assign row_done = dir_i ? (x_bwd < llx_w) : (x_fwd > urx_w);

  always_comb begin
    nxt_x_o = cur_x_i;
    nxt_y_o = cur_y_i;
    dir_o   = dir_i;
    if (row_done) begin
      nxt_y_o = y_inc[SIGFIG-1:0];
      dir_o   = ~dir_i;
    end else if (dir_i) begin
      nxt_x_o = x_bwd[SIGFIG-1:0];
    end else begin
      nxt_x_o = x_fwd[SIGFIG-1:0];
    end
  end
`else
  assign row_done = x_fwd > urx_w;
  assign dir_o    = dir_i;

  always_comb begin
    nxt_x_o = x_fwd[SIGFIG-1:0];
    nxt_y_o = cur_y_i;
    if (row_done) begin
      nxt_x_o = ll_x_i;
      nxt_y_o = y_inc[SIGFIG-1:0];
    end
  end
`endif

endmodule

// File: rtl/sample_walker.sv
// Walks a sample grid over one bounding-boxed triangle at a time for sampletest.
// Define WALKER_SERPENTINE_EN to alternate row direction.
module sample_walker
  import walker_pkg::*;
#(
  parameter int unsigned SIGFIG = 24,
  parameter int unsigned RADIX  = 10,
  parameter int unsigned VERTS  = 3,
  parameter int unsigned AXIS   = 3,
  parameter int unsigned COLORS = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic signed [SIGFIG-1:0] tri_R13S [VERTS][AXIS],
  input  logic        [SIGFIG-1:0] color_R13U [COLORS],
  input  logic signed [SIGFIG-1:0] box_R13S [2][2],
  input  logic                     validTri_R13H,
  input  logic        [3:0]        subSample_RnnnnU,
  input  logic                     halt_RnnnnH,
  output logic                     halt_R13H,
  output logic signed [SIGFIG-1:0] tri_R14S [VERTS][AXIS],
  output logic        [SIGFIG-1:0] color_R14U [COLORS],
  output logic signed [SIGFIG-1:0] sample_R14S [2],
  output logic                     validSamp_R14H
);

  localparam logic [SIGFIG:0] StepUnit = (SIGFIG+1)'(1);

  walk_state_e state_q, state_d;
  logic signed [SIGFIG-1:0] samp_x_q, samp_x_d, samp_y_q, samp_y_d;
  logic signed [SIGFIG-1:0] ll_x_q, ll_y_q, ur_x_q, ur_y_q;
  logic signed [SIGFIG-1:0] tri_q [VERTS][AXIS];
  logic        [SIGFIG-1:0] color_q [COLORS];
  logic valid_q, valid_d, load;

  logic [1:0]               sub_k;
  logic [SIGFIG:0]          step;
  logic signed [SIGFIG-1:0] nxt_x, nxt_y;
  logic                     walk_last, dir_q, dir_nxt;

  assign sub_k = step_shift(subSample_RnnnnU);
  assign step  = StepUnit << (RADIX - 32'(sub_k));

`ifdef WALKER_SERPENTINE_EN
  logic dir_d;
`else
  assign dir_q = 1'b0;
  logic unused_dir;
  assign unused_dir = dir_nxt;
`endif

  sample_walk_next #(
    .SIGFIG (SIGFIG)
  ) u_next (
    .cur_x_i (samp_x_q),
    .cur_y_i (samp_y_q),
    .ll_x_i  (ll_x_q),
    .ll_y_i  (ll_y_q),
    .ur_x_i  (ur_x_q),
    .ur_y_i  (ur_y_q),
    .step_i  (step),
    .dir_i   (dir_q),
    .nxt_x_o (nxt_x),
    .nxt_y_o (nxt_y),
    .dir_o   (dir_nxt),
    .last_o  (walk_last)
  );

  always_comb begin
    state_d  = state_q;
    samp_x_d = samp_x_q;
    samp_y_d = samp_y_q;
    valid_d  = valid_q;
    load     = 1'b0;
`ifdef WALKER_SERPENTINE_EN
    dir_d    = dir_q;
`endif
    // Downstream halt freezes every register.
    if (!halt_RnnnnH) begin
      unique case (state_q)
        StWait: begin
          if (validTri_R13H) begin
            load     = 1'b1;
            samp_x_d = box_R13S[0][0];
            samp_y_d = box_R13S[0][1];
            valid_d  = 1'b1;
            state_d  = StTest;
`ifdef WALKER_SERPENTINE_EN
            dir_d    = 1'b0;
`endif
          end else begin
            valid_d = 1'b0;
          end
        end
        StTest: begin
          if (walk_last) begin
            valid_d = 1'b0;
            state_d = StWait;
          end else begin
            samp_x_d = nxt_x;
            samp_y_d = nxt_y;
`ifdef WALKER_SERPENTINE_EN
            dir_d    = dir_nxt;
`endif
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StWait;
      samp_x_q <= '0;
      samp_y_q <= '0;
      valid_q  <= 1'b0;
      ll_x_q   <= '0;
      ll_y_q   <= '0;
      ur_x_q   <= '0;
      ur_y_q   <= '0;
      tri_q    <= '{default: '0};
      color_q  <= '{default: '0};
`ifdef WALKER_SERPENTINE_EN
      dir_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      samp_x_q <= samp_x_d;
      samp_y_q <= samp_y_d;
      valid_q  <= valid_d;
`ifdef WALKER_SERPENTINE_EN
      dir_q    <= dir_d;
`endif
      if (load) begin
        ll_x_q  <= box_R13S[0][0];
        ll_y_q  <= box_R13S[0][1];
        ur_x_q  <= box_R13S[1][0];
        ur_y_q  <= box_R13S[1][1];
        tri_q   <= tri_R13S;
        color_q <= color_R13U;
      end
    end
  end

  assign halt_R13H      = (state_q == StTest) || halt_RnnnnH;
  assign tri_R14S       = tri_q;
  assign color_R14U     = color_q;
  assign sample_R14S[0] = samp_x_q;
  assign sample_R14S[1] = samp_y_q;
  assign validSamp_R14H = valid_q;

endmodule

// File: tb/tb_sample_walker.sv
// Self-checking bench for sample_walker: vector table plus scoreboard of expected samples.
module tb_sample_walker;

  localparam int SIGFIG = 24;
  localparam int VERTS  = 3;
  localparam int AXIS   = 3;
  localparam int COLORS = 3;
`ifdef WALKER_SERPENTINE_EN
  localparam bit Serp = 1'b1;
`else
  localparam bit Serp = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic signed [SIGFIG-1:0] tri_i [VERTS][AXIS];
  logic        [SIGFIG-1:0] color_i [COLORS];
  logic signed [SIGFIG-1:0] box_i [2][2];
  logic                     valid_tri;
  logic        [3:0]        sub;
  logic                     halt_in;
  logic                     halt_out;
  logic signed [SIGFIG-1:0] tri_o [VERTS][AXIS];
  logic        [SIGFIG-1:0] color_o [COLORS];
  logic signed [SIGFIG-1:0] sample_o [2];
  logic                     valid_o;

  sample_walker dut (
    .clk              (clk),
    .rst              (rst),
    .tri_R13S         (tri_i),
    .color_R13U       (color_i),
    .box_R13S         (box_i),
    .validTri_R13H    (valid_tri),
    .subSample_RnnnnU (sub),
    .halt_RnnnnH      (halt_in),
    .halt_R13H        (halt_out),
    .tri_R14S         (tri_o),
    .color_R14U       (color_o),
    .sample_R14S      (sample_o),
    .validSamp_R14H   (valid_o)
  );

  always #5 clk = ~clk;

  typedef struct { int x; int y; int col; } exp_t;
  typedef struct { int llx; int lly; int urx; int ury; logic [3:0] s; int n; } vec_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;
  int   n_pop = 0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Consume one sample whenever downstream is not halting.
  always @(negedge clk) begin
    if (!rst && valid_o && !halt_in) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_sample", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        n_pop++;
        chk("sample_x", int'(sample_o[0]), mon_e.x);
        chk("sample_y", int'(sample_o[1]), mon_e.y);
        chk("color", int'(color_o[COLORS-1]), mon_e.col + COLORS - 1);
        chk("tri", int'(tri_o[VERTS-1][AXIS-1]), mon_e.col * 16 + (VERTS-1) * 3 + AXIS - 1);
      end
    end
  end

  function automatic int push_walk(input int llx, input int lly, input int urx, input int ury,
                                   input logic [3:0] s, input int col);
    int   st, n, row, xe;
    exp_t e;
    case (s)
      4'b1000: st = 1024;
      4'b0100: st = 512;
      4'b0010: st = 256;
      4'b0001: st = 128;
      default: st = 1024;
    endcase
    n     = 0;
    row   = 0;
    e.col = col;
    if (urx < llx || ury < lly) begin
      e.x = llx;
      e.y = lly;
      exp_q.push_back(e);
      return 1;
    end
    xe = llx + ((urx - llx) / st) * st;
    for (int y = lly; y <= ury; y += st) begin
      e.y = y;
      if (Serp && (row % 2 == 1)) begin
        for (int x = xe; x >= llx; x -= st) begin
          e.x = x;
          exp_q.push_back(e);
          n++;
        end
      end else begin
        for (int x = llx; x <= urx; x += st) begin
          e.x = x;
          exp_q.push_back(e);
          n++;
        end
      end
      row++;
    end
    return n;
  endfunction

  task automatic set_tri(input int llx, input int lly, input int urx, input int ury,
                         input logic [3:0] s, input int col);
    box_i[0][0] = SIGFIG'(llx);
    box_i[0][1] = SIGFIG'(lly);
    box_i[1][0] = SIGFIG'(urx);
    box_i[1][1] = SIGFIG'(ury);
    sub = s;
    for (int v = 0; v < VERTS; v++)
      for (int a = 0; a < AXIS; a++) tri_i[v][a] = SIGFIG'(col * 16 + v * 3 + a);
    for (int c = 0; c < COLORS; c++) color_i[c] = SIGFIG'(col + c);
  endtask

  task automatic launch(input int llx, input int lly, input int urx, input int ury,
                        input logic [3:0] s, input int col);
    set_tri(llx, lly, urx, ury, s, col);
    valid_tri = 1'b1;
    @(posedge clk);
    #1;
    valid_tri = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || valid_o) && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk(name, exp_q.size() + int'(valid_o), 0);
    exp_q.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t tbl[9];
  int   tv[6];
  int   th[6];
  int   tx[6];
  int   ty[6];
  int   m;
  int   p0;

  initial begin
    tbl[0] = '{0, 0, 0, 0, 4'b1000, 1};
    tbl[1] = '{0, 0, 1024, 1024, 4'b1000, 4};
    tbl[2] = '{0, 0, 1024, 1024, 4'b0100, 9};
    tbl[3] = '{0, 0, 1024, 1024, 4'b0010, 25};
    tbl[4] = '{-2048, -1024, -1024, 0, 4'b1000, 4};
    tbl[5] = '{1024, 0, 0, 1024, 4'b1000, 1};
    tbl[6] = '{0, 0, 1024, 0, 4'b0110, 2};
    tbl[7] = '{8386560, 8387584, 8387584, 8387584, 4'b1000, 2};
    tbl[8] = '{0, 0, 256, 128, 4'b0001, 6};

    // Reset state, with halt passing straight through.
    rst       = 1'b1;
    halt_in   = 1'b1;
    valid_tri = 1'b0;
    set_tri(0, 0, 0, 0, 4'b1000, 0);
    #3;
    chk("rst_halt_pass_hi", int'(halt_out), 1);
    chk("rst_valid", int'(valid_o), 0);
    chk("rst_sample_x", int'(sample_o[0]), 0);
    chk("rst_color", int'(color_o[0]), 0);
    halt_in = 1'b0;
    #1;
    chk("rst_halt_pass_lo", int'(halt_out), 0);
    @(negedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_valid", int'(valid_o), 0);

    for (int i = 0; i < 9; i++) begin
      m  = push_walk(tbl[i].llx, tbl[i].lly, tbl[i].urx, tbl[i].ury, tbl[i].s, i + 1);
      p0 = n_pop;
      launch(tbl[i].llx, tbl[i].lly, tbl[i].urx, tbl[i].ury, tbl[i].s, i + 1);
      wait_idle($sformatf("drain_%0d", i), 200);
      chk($sformatf("count_%0d", i), n_pop - p0, tbl[i].n);
    end

    // Degenerate box: halt_R13H high only on the single sample cycle.
    m = push_walk(0, 0, 0, 0, 4'b1000, 30);
    launch(0, 0, 0, 0, 4'b1000, 30);
    chk("degen_valid_n1", int'(valid_o), 1);
    chk("degen_halt_n1", int'(halt_out), 1);
    @(posedge clk);
    #1;
    chk("degen_valid_n2", int'(valid_o), 0);
    chk("degen_halt_n2", int'(halt_out), 0);
    wait_idle("degen_drain", 20);

    // Back-to-back triangles: one WAIT bubble, next acceptance at N+5.
    m = push_walk(0, 0, 1024, 1024, 4'b1000, 20);
    m = push_walk(0, 0, 1024, 1024, 4'b1000, 20);
    tv = '{1, 1, 1, 1, 0, 1};
    th = '{1, 1, 1, 1, 0, 1};
    tx = '{0, 1024, 0, 1024, 1024, 0};
    ty = '{0, 0, 1024, 1024, 1024, 0};
    set_tri(0, 0, 1024, 1024, 4'b1000, 20);
    valid_tri = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("b2b_valid_%0d", c), int'(valid_o), tv[c]);
      chk($sformatf("b2b_halt_%0d", c), int'(halt_out), th[c]);
      chk($sformatf("b2b_x_%0d", c), int'(sample_o[0]), tx[c]);
      chk($sformatf("b2b_y_%0d", c), int'(sample_o[1]), ty[c]);
      if (c == 5) valid_tri = 1'b0;
    end
    wait_idle("b2b_drain", 40);

    // Downstream halt for three cycles while the second sample is shown.
    m = push_walk(0, 0, 1024, 1024, 4'b1000, 40);
    launch(0, 0, 1024, 1024, 4'b1000, 40);
    @(posedge clk);
    #1;
    chk("halt_pre_x", int'(sample_o[0]), 1024);
    halt_in = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("halt_hold_x_%0d", k), int'(sample_o[0]), 1024);
      chk($sformatf("halt_hold_y_%0d", k), int'(sample_o[1]), 0);
      chk($sformatf("halt_hold_v_%0d", k), int'(valid_o), 1);
      chk($sformatf("halt_up_%0d", k), int'(halt_out), 1);
    end
    halt_in = 1'b0;
    wait_idle("halt_drain", 40);

    // Halt in WAIT blocks acceptance until released.
    m = push_walk(0, 0, 0, 0, 4'b1000, 70);
    set_tri(0, 0, 0, 0, 4'b1000, 70);
    halt_in   = 1'b1;
    valid_tri = 1'b1;
    @(posedge clk);
    #1;
    chk("halt_blocks_accept", int'(valid_o), 0);
    halt_in = 1'b0;
    @(posedge clk);
    #1;
    valid_tri = 1'b0;
    chk("accept_after_halt", int'(valid_o), 1);
    wait_idle("halt_wait_drain", 20);

    // Reset mid-walk, with a new triangle waiting across the release.
    m = push_walk(0, 0, 1024, 1024, 4'b1000, 50);
    launch(0, 0, 1024, 1024, 4'b1000, 50);
    @(posedge clk);
    #2;
    rst = 1'b1;
    exp_q.delete();
    set_tri(2048, 1024, 3072, 1024, 4'b1000, 60);
    valid_tri = 1'b1;
    #1;
    chk("midrst_valid", int'(valid_o), 0);
    chk("midrst_x", int'(sample_o[0]), 0);
    chk("midrst_y", int'(sample_o[1]), 0);
    chk("midrst_color", int'(color_o[0]), 0);
    chk("midrst_tri", int'(tri_o[0][0]), 0);
    chk("midrst_halt", int'(halt_out), 0);
    m = push_walk(2048, 1024, 3072, 1024, 4'b1000, 60);
    @(negedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    valid_tri = 1'b0;
    chk("postrst_valid", int'(valid_o), 1);
    chk("postrst_x", int'(sample_o[0]), 2048);
    wait_idle("postrst_drain", 20);

`ifdef WALKER_SERPENTINE_EN
    m  = push_walk(0, 0, 2048, 1024, 4'b1000, 80);
    p0 = n_pop;
    launch(0, 0, 2048, 1024, 4'b1000, 80);
    wait_idle("serp_drain", 40);
    chk("serp_count", n_pop - p0, 6);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sample_walker.md
# sample_walker

Sequencer that feeds the sample-test stage. It accepts one bounding-boxed triangle at a time from the bounding-box stage and walks a sample grid over the box at the configured subsample spacing. Each cycle it presents the triangle, its colour and one sample location with a valid flag to `sampletest`. It stalls upstream while a walk is in progress and freezes when downstream halts.

## Interface
Parameters:
- `SIGFIG`, 24, bits in position/colour words
- `RADIX`, 10, fraction bits
- `VERTS`, 3, vertices per triangle
- `AXIS`, 3, axes per vertex (x,y,z)
- `COLORS`, 3, colour channels

Ports:
- `clk`  in  1  clock; the block has exactly one clock
- `rst`  in  1  reset, asynchronous, active-high
- `tri_R13S`  in  [VERTS][AXIS]×SIGFIG signed  triangle from bounding box
- `color_R13U`  in  [COLORS]×SIGFIG  triangle colour
- `box_R13S`  in  [2][2]×SIGFIG signed  box; [0]=lower-left (x,y), [1]=upper-right (x,y); already snapped to the sample grid
- `validTri_R13H`  in  1  triangle/box valid
- `subSample_RnnnnU`  in  4  one-hot spacing: 1000 = 1 px, 0100 = 1/2, 0010 = 1/4, 0001 = 1/8; static during a walk
- `halt_RnnnnH`  in  1  downstream stall
- `halt_R13H`  out  1  upstream stall
- `tri_R14S`, `color_R14U`  out  same shapes as inputs  latched triangle and colour
- `sample_R14S`  out  [2]×SIGFIG signed  sample (x,y)
- `validSamp_R14H`  out  1  sample valid

## Operation
- Spacing: step = 1 << (RADIX − k), where k = 0/1/2/3 for 1000/0100/0010/0001. A non-one-hot code is treated as 1000.
- FSM has two states, WAIT and TEST. Reset state is WAIT.
- `halt_R13H` = (state==TEST) | `halt_RnnnnH`.
- WAIT, with `validTri_R13H` high and `halt_RnnnnH` low:
  - Latch the triangle, colour and box.
  - Set `sample_R14S` = lower-left and `validSamp_R14H` = 1.
  - Go to TEST.
- WAIT otherwise: `validSamp_R14H` = 0 and all other registers hold.
- TEST, raster order:
  - nx = x + step.
  - If nx ≤ ur_x: x = nx.
  - Else: x = ll_x and y = y + step.
  - End of walk when nx > ur_x and y + step > ur_y. On the end cycle, set `validSamp_R14H` = 0 and go to WAIT. Sample registers hold.
- Arithmetic: next-position adds and compares are done in SIGFIG+1 signed bits so a box near the positive limit cannot wrap.
- Degenerate box (ll == ur): exactly one sample is emitted.
- Inverted box (ur < ll on either axis, as input): the triangle is accepted and one sample at ll is emitted. Upstream must not produce inverted boxes.
- `halt_RnnnnH` high: every register (state, sample, valid, triangle) holds. Outputs are stable for the whole halt.
- `rst` asserted at any time, including mid-walk:
  - The walk in progress is abandoned.
  - State returns to WAIT.
  - `validSamp_R14H` = 0, `sample_R14S` = 0, `tri_R14S` = 0, `color_R14U` = 0.
  - `halt_R13H` = `halt_RnnnnH`.

## Timing
- A triangle accepted at edge N shows its first sample after edge N. A box of S samples gives valid samples on cycles N+1..N+S, not counting halt cycles.
- `halt_R13H` is high from cycle N+1 through cycle N+S.
- After each triangle there is exactly one WAIT bubble cycle. The earliest next acceptance is at edge N+S+1.
- No combinational path exists from `validTri_R13H` to any output.

## Configuration
- `WALKER_SERPENTINE_EN` defined: rows alternate direction.
  - Even rows walk left to right, odd rows right to left.
  - At a row end, x holds, y += step, and direction toggles.
  - The walk ends when the row is exhausted and y + step > ur_y.
  - The direction bit resets to left-to-right on reset and on each acceptance.
- Not defined: the raster order described under Operation. No direction flop exists.

## Structure
- Shared package `walker_pkg` holds:
  - the state enum (WAIT, TEST);
  - the subsample code constants;
  - the step-decode function.
- One combinational sub-module, `sample_walk_next`: takes the current sample, box, step and direction, and returns the next sample, the new direction and `last`.
- The FSM and registers live in `sample_walker`.

## Test plan
- Box ll=ur=(0,0), 1 px step, accepted at N → one valid sample (0,0) on N+1; WAIT on N+2; `halt_R13H` high only on N+1.
- Box (0,0)–(1024,1024), 1 px step → samples (0,0),(1024,0),(0,1024),(1024,1024) on N+1..N+4; valid low on N+5; next triangle accepted at N+5.
- Same box, half-pixel step (0100) → 9 samples with x,y ∈ {0,512,1024}, raster order.
- `halt_RnnnnH` high for 3 cycles after the second sample → sample (1024,0) held 3 extra cycles with valid high, then the sequence resumes unchanged.
- `rst` asserted mid-walk → all outputs zero immediately; an asserted `validTri_R13H` is accepted on the first edge after reset release.
- `WALKER_SERPENTINE_EN`, 3×2 grid (0..2048 x, 0..1024 y) → (0,0),(1024,0),(2048,0),(2048,1024),(1024,1024),(0,1024).
